// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped 2-bit counter table with a tagged BTB,
// trained from resolved branches, plus branch/mispredict statistics counters.
module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_LSB = INDEX_BITS + 2;
  localparam int TAG_MSB = INDEX_BITS + TAG_BITS + 1;

  logic                valid_q  [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];

  logic [INDEX_BITS-1:0] if_idx, upd_idx;
  logic [TAG_BITS-1:0]   if_tag, upd_tag;

  assign if_idx  = if_pc[INDEX_BITS+1:2];
  assign if_tag  = if_pc[TAG_MSB:TAG_LSB];
  assign upd_idx = upd_pc[INDEX_BITS+1:2];
  assign upd_tag = upd_pc[TAG_MSB:TAG_LSB];

  // Bits of the update PC that neither index nor tag the table.
  logic unused_upd_pc_bits;
  assign unused_upd_pc_bits = ^{upd_pc[31:TAG_MSB+1], upd_pc[1:0]};

  // Lookup reads the registered table only, so a same-cycle update is not bypassed.
  always_comb begin
    pred_hit    = if_valid & valid_q[if_idx] & (tag_q[if_idx] == if_tag);
    pred_taken  = pred_hit & ctr_q[if_idx][1];
    pred_target = pred_taken ? target_q[if_idx] : if_pc + 32'd4;
  end

  logic        upd_hit;
  logic [1:0]  cur_ctr;
  logic        meta_we;
  logic        data_we;
  logic [1:0]  entry_ctr_d;
  logic        mispredict_d;
  logic [31:0] branch_count_d, branch_count_q;
  logic [31:0] mispredict_count_d, mispredict_count_q;
  logic        mispredict_q;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it
    // unassigned; an incomplete assignment here would infer a latch.
    upd_hit            = valid_q[upd_idx] & (tag_q[upd_idx] == upd_tag);
    cur_ctr            = ctr_q[upd_idx];
    meta_we            = 1'b0;
    data_we            = 1'b0;
    entry_ctr_d        = cur_ctr;
    mispredict_d       = 1'b0;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;

    if (upd_valid) begin
      if (upd_taken) begin
        meta_we     = 1'b1;
        data_we     = 1'b1;
        entry_ctr_d = !upd_hit ? 2'b10 : (cur_ctr == 2'b11) ? 2'b11 : cur_ctr + 2'd1;
      end else if (upd_hit) begin
        meta_we     = 1'b1;
        entry_ctr_d = (cur_ctr == 2'b00) ? 2'b00 : cur_ctr - 2'd1;
      end

      mispredict_d = (upd_pred_taken != upd_taken) |
                     (upd_taken & upd_pred_taken & (upd_pred_target != upd_target));

      if (branch_count_q != 32'hFFFF_FFFF) branch_count_d = branch_count_q + 32'd1;
      if (mispredict_d && mispredict_count_q != 32'hFFFF_FFFF)
        mispredict_count_d = mispredict_count_q + 32'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
      mispredict_q       <= 1'b0;
      branch_count_q     <= 32'd0;
      mispredict_count_q <= 32'd0;
    end else begin
      if (meta_we) begin
        valid_q[upd_idx] <= 1'b1;
        ctr_q[upd_idx]   <= entry_ctr_d;
      end
      mispredict_q       <= mispredict_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  // NOTE: tag and target storage is deliberately left unreset; the valid bit
  // masks stale contents, and skipping reset keeps this a plain RAM.
  always_ff @(posedge clk) begin
    if (data_we) begin
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= upd_target;
    end
  end

  assign mispredict       = mispredict_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table, hand-written
// collision/async-reset sequences, then random traffic against a reference model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] branch_count, mispredict_count;

  int n_checks = 0;
  int n_errors = 0;

  branch_predictor dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_valid         (if_valid),
    .if_pc            (if_pc),
    .pred_hit         (pred_hit),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_pred_taken   (upd_pred_taken),
    .upd_pred_target  (upd_pred_target),
    .mispredict       (mispredict),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        upt;
    logic [31:0] uptgt;
    logic        lv;
    logic [31:0] lpc;
    logic        eh;
    logic        et;
    logic [31:0] etgt;
    logic        emp;
    logic [31:0] ebc;
    logic [31:0] emc;
  } vec_t;

  vec_t vecs[13];

  // Reference model: plain integer counters 0..3 per entry.
  bit          m_valid  [64];
  int          m_tag    [64];
  logic [31:0] m_target [64];
  int          m_ctr    [64];
  longint      m_bc, m_mc;

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_bc = 0;
    m_mc = 0;
  endtask

  task automatic model_lookup(input logic v, input logic [31:0] pc,
                              output logic h, output logic t, output logic [31:0] tg);
    int idx, tag;
    idx = int'((pc / 4) % 64);
    tag = int'((pc / 256) % 256);
    h   = v && m_valid[idx] && (m_tag[idx] == tag);
    t   = h && (m_ctr[idx] >= 2);
    tg  = t ? m_target[idx] : pc + 32'd4;
  endtask

  task automatic model_update(input logic [31:0] pc, input logic taken,
                              input logic [31:0] tgt, input logic mp);
    int idx, tag;
    bit hit;
    idx = int'((pc / 4) % 64);
    tag = int'((pc / 256) % 256);
    hit = m_valid[idx] && (m_tag[idx] == tag);
    if (taken) begin
      if (hit) begin
        m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
      end else begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tag;
        m_ctr[idx]   = 2;
      end
      m_target[idx] = tgt;
    end else if (hit) begin
      m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
    end
    if (m_bc < 64'hFFFF_FFFF) m_bc++;
    if (mp && m_mc < 64'hFFFF_FFFF) m_mc++;
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 9) == 0) return $urandom & 32'hFFFF_FFFC;
    return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
  endfunction

  initial begin
    logic        eh, et, emp;
    logic [31:0] etgt;

    rst_n = 1'b0; if_valid = 1'b0; if_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    upd_pred_taken = 1'b0; upd_pred_target = '0;

    //           uv    upc            ut    utgt           upt   uptgt          lv    lpc            eh    et    etgt           emp   bc     mc
    vecs[0]  = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h100,       1'b0, 1'b0, 32'h104,       1'b0, 32'd0, 32'd0};
    vecs[1]  = '{1'b1, 32'h100,       1'b1, 32'h80,        1'b0, 32'h104,       1'b1, 32'h100,       1'b1, 1'b1, 32'h80,        1'b1, 32'd1, 32'd1};
    vecs[2]  = '{1'b1, 32'h100,       1'b1, 32'h80,        1'b1, 32'h80,        1'b1, 32'h100,       1'b1, 1'b1, 32'h80,        1'b0, 32'd2, 32'd1};
    vecs[3]  = '{1'b1, 32'h100,       1'b1, 32'h80,        1'b1, 32'h80,        1'b1, 32'h100,       1'b1, 1'b1, 32'h80,        1'b0, 32'd3, 32'd1};
    vecs[4]  = '{1'b1, 32'h100,       1'b1, 32'h80,        1'b1, 32'h80,        1'b1, 32'h100,       1'b1, 1'b1, 32'h80,        1'b0, 32'd4, 32'd1};
    vecs[5]  = '{1'b1, 32'h100,       1'b0, 32'h80,        1'b1, 32'h80,        1'b1, 32'h100,       1'b1, 1'b1, 32'h80,        1'b1, 32'd5, 32'd2};
    vecs[6]  = '{1'b1, 32'h100,       1'b0, 32'h80,        1'b1, 32'h80,        1'b1, 32'h100,       1'b1, 1'b0, 32'h104,       1'b1, 32'd6, 32'd3};
    vecs[7]  = '{1'b1, 32'h4100,      1'b1, 32'h200,       1'b0, 32'h4104,      1'b1, 32'h100,       1'b0, 1'b0, 32'h104,       1'b1, 32'd7, 32'd4};
    vecs[8]  = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h4100,      1'b1, 1'b1, 32'h200,       1'b0, 32'd7, 32'd4};
    vecs[9]  = '{1'b1, 32'h8100,      1'b0, 32'h999,       1'b0, 32'h8104,      1'b1, 32'h4100,      1'b1, 1'b1, 32'h200,       1'b0, 32'd8, 32'd4};
    vecs[10] = '{1'b1, 32'h4100,      1'b1, 32'h300,       1'b1, 32'h200,       1'b1, 32'h4100,      1'b1, 1'b1, 32'h300,       1'b1, 32'd9, 32'd5};
    vecs[11] = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0,         1'b0, 32'd9, 32'd5};
    vecs[12] = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h4100,      1'b0, 1'b0, 32'h4104,      1'b0, 32'd9, 32'd5};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed table: update on one edge, then look up the post-update state.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      upd_valid = vecs[i].uv;  upd_pc = vecs[i].upc;  upd_taken = vecs[i].ut;
      upd_target = vecs[i].utgt; upd_pred_taken = vecs[i].upt; upd_pred_target = vecs[i].uptgt;
      if_valid = 1'b0;
      @(posedge clk);
      #1;
      upd_valid = 1'b0;
      if_valid  = vecs[i].lv;
      if_pc     = vecs[i].lpc;
      #1;
      check($sformatf("v%0d pred_hit", i),         32'(pred_hit),   32'(vecs[i].eh));
      check($sformatf("v%0d pred_taken", i),       32'(pred_taken), 32'(vecs[i].et));
      check($sformatf("v%0d pred_target", i),      pred_target,     vecs[i].etgt);
      check($sformatf("v%0d mispredict", i),       32'(mispredict), 32'(vecs[i].emp));
      check($sformatf("v%0d branch_count", i),     branch_count,    vecs[i].ebc);
      check($sformatf("v%0d mispredict_count", i), mispredict_count, vecs[i].emc);
    end

    // Same-cycle lookup and allocating update of pc 0x40: no bypass.
    @(negedge clk);
    if_valid = 1'b1; if_pc = 32'h40;
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h500;
    upd_pred_taken = 1'b0; upd_pred_target = 32'h44;
    #1;
    check("collide same-cycle hit", 32'(pred_hit), 32'd0);
    check("collide same-cycle target", pred_target, 32'h44);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    #1;
    check("collide next hit", 32'(pred_hit), 32'd1);
    check("collide next target", pred_target, 32'h500);
    check("collide mispredict", 32'(mispredict), 32'd1);
    check("collide branch_count", branch_count, 32'd10);

    // Async reset between edges while an update is presented.
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h700;
    upd_pred_taken = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async branch_count", branch_count, 32'd0);
    check("async mispredict_count", mispredict_count, 32'd0);
    check("async mispredict", 32'(mispredict), 32'd0);
    upd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    if_valid = 1'b1;
    if_pc = 32'h4100; #1 check("post-reset 0x4100 hit", 32'(pred_hit), 32'd0);
    if_pc = 32'h40;   #1 check("post-reset 0x40 hit", 32'(pred_hit), 32'd0);
    if_pc = 32'h100;  #1 check("post-reset 0x100 hit", 32'(pred_hit), 32'd0);
    check("post-reset 0x100 target", pred_target, 32'h104);
    @(posedge clk);
    #1;
    check("post-reset branch_count", branch_count, 32'd0);

    // Random traffic against the reference model.
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      logic        mh, mt;
      logic [31:0] mtg;
      @(negedge clk);
      if_valid  = 1'($urandom_range(0, 3) != 0);
      if_pc     = rand_pc();
      upd_valid = 1'($urandom_range(0, 2) != 0);
      upd_pc    = rand_pc();
      upd_taken = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       upd_target = 32'h1000;
        1:       upd_target = 32'h2000;
        default: upd_target = $urandom & 32'hFFFF_FFFC;
      endcase
      model_lookup(1'b1, upd_pc, mh, mt, mtg);
      if ($urandom_range(0, 1) == 0) begin
        upd_pred_taken  = mt;
        upd_pred_target = mtg;
      end else begin
        upd_pred_taken  = 1'($urandom_range(0, 1));
        upd_pred_target = ($urandom_range(0, 1) == 0) ? upd_target : upd_pc + 32'd4;
      end
      #1;
      model_lookup(if_valid, if_pc, eh, et, etgt);
      check("rand pred_hit",    32'(pred_hit),   32'(eh));
      check("rand pred_taken",  32'(pred_taken), 32'(et));
      check("rand pred_target", pred_target,     etgt);
      emp = upd_valid && ((upd_pred_taken != upd_taken) ||
                          (upd_taken && upd_pred_taken && upd_pred_target != upd_target));
      @(posedge clk);
      if (upd_valid) model_update(upd_pc, upd_taken, upd_target, emp);
      #1;
      check("rand mispredict",       32'(mispredict),  32'(emp));
      check("rand branch_count",     branch_count,     32'(m_bc));
      check("rand mispredict_count", mispredict_count, 32'(m_mc));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side counterpart to the branch decision unit.
- Predicts direction and target for the PC being fetched, using a direct-mapped table of 2-bit saturating counters plus a tagged branch target buffer (BTB).
- Trains from the resolved outcome: BranchTaken, the branch PC and the computed target, supplied by the execute stage.
- Also keeps branch and mispredict statistics counters for performance bring-up.

Parameters:
- INDEX_BITS, 6, log2 of table entries (64); table index = pc[INDEX_BITS+1:2].
- TAG_BITS, 8, stored tag width; tag = pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2].

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- if_valid  input  1  fetch lookup request this cycle.
- if_pc  input  32  PC being fetched.
- pred_hit  output  1  valid entry with matching tag for if_pc.
- pred_taken  output  1  predicted taken.
- pred_target  output  32  predicted next PC.
- upd_valid  input  1  resolved conditional branch this cycle (Branch asserted in execute).
- upd_pc  input  32  PC of resolved branch.
- upd_taken  input  1  actual outcome (BranchTaken).
- upd_target  input  32  computed branch target.
- upd_pred_taken  input  1  prediction that was made for this branch.
- upd_pred_target  input  32  next PC that was predicted for this branch.
- mispredict  output  1  registered; pulses one cycle after a mispredicted update.
- branch_count  output  32  resolved branches since reset.
- mispredict_count  output  32  mispredicts since reset.

Behaviour:
- Storage per entry: valid bit, TAG_BITS tag, 32-bit target, 2-bit counter (00 strong NT, 01 weak NT, 10 weak T, 11 strong T).
- Reset (asynchronous, rst_n low), all cleared regardless of in-flight update:
  - every valid bit = 0;
  - every counter = 01;
  - mispredict = 0, branch_count = 0, mispredict_count = 0.
  - Tags and targets need no reset.
- Lookup is combinational, zero latency, same cycle as if_pc:
  - pred_hit = if_valid & valid[idx] & (tag[idx] == if_pc tag).
  - pred_taken = pred_hit & counter[idx][1].
  - pred_target = target[idx] when pred_taken, else if_pc + 4 (mod 2^32; 0xFFFFFFFC wraps to 0x00000000).
  - if_valid = 0: pred_hit = 0, pred_taken = 0, pred_target = if_pc + 4.
- Update is sequential, on the rising clk edge with upd_valid = 1; entry selected by upd_pc index:
  - Taken, tag match and valid: counter increments, saturating at 11; target overwritten with upd_target.
  - Taken, miss (invalid or tag mismatch): allocate, i.e. valid = 1, tag written, target = upd_target, counter = 10.
  - Not taken, tag match and valid: counter decrements, saturating at 00; target unchanged.
  - Not taken, miss: no table change; no allocation on not-taken.
- Simultaneous lookup and update on the same entry: lookup returns the pre-update state, with no bypass. The new state is visible from the next cycle.
- Mispredict condition: upd_valid & ((upd_pred_taken != upd_taken) | (upd_taken & upd_pred_taken & (upd_pred_target != upd_target))).
- Statistics, on each upd_valid edge:
  - branch_count increments.
  - mispredict_count increments when the mispredict condition holds.
  - Both saturate at 0xFFFFFFFF and never wrap.
- mispredict is a flop of the mispredict condition, valid the cycle after the update; it is 0 when upd_valid = 0.
- upd_valid = 0: no state changes, apart from mispredict clearing.
- Reset asserted mid-update: the asynchronous clear wins, and the update is lost.

Test Plan:
- Reset then lookup: if_valid = 1, if_pc = 0x00000100 -> pred_hit = 0, pred_taken = 0, pred_target = 0x00000104; all counters 0.
- Allocate: update pc 0x100, taken = 1, target 0x80, pred_taken = 0 -> next cycle mispredict = 1; lookup 0x100 gives hit, pred_taken = 1, target 0x80; branch_count = 1, mispredict_count = 1.
- Saturation and hysteresis on pc 0x100: three more taken updates (counter 11), then one not-taken -> counter 10, still pred_taken = 1; a second not-taken -> 01, pred_taken = 0, pred_target = 0x104.
- Alias: pc 0x100 allocated, then update pc 0x4100 (same index, different tag) taken, target 0x200 -> lookup 0x100 gives pred_hit = 0; lookup 0x4100 gives target 0x200. A not-taken update on a missing pc leaves the entry untouched.
- Same-cycle collision: lookup and taken update of an unallocated pc 0x40 in one cycle -> pred_hit = 0 that cycle, pred_hit = 1 next cycle.
- Async reset mid-operation: drop rst_n between clock edges with upd_valid = 1 -> counts = 0 and mispredict = 0 immediately; lookup of a previously allocated pc misses after reset release.
- Wrap: if_pc = 0xFFFFFFFC, miss -> pred_target = 0x00000000.
